// File: rtl/rom_boot_copier_pkg.sv
// Shared types for the boot ROM copier: FSM states, TL-UL opcodes and the
// checksum rotate helper.
package rom_boot_copier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_RSP,
    ST_WR_REQ,
    ST_WR_RSP,
    ST_DONE,
    ST_ERR
  } boot_state_e;

  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpPutFullData   = 3'd0;
  localparam logic [2:0] OpAccessAck     = 3'd0;
  localparam logic [2:0] OpAccessAckData = 3'd1;

  function automatic logic [31:0] rotl1(input logic [31:0] v);
    return {v[30:0], v[31]};
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types (32-bit data bus) shared by hosts and devices.
package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tlul_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tlul_d2h_t;

endpackage

// File: rtl/rom_boot_copier.sv
// TL-UL host that copies NumWords words from boot ROM to RAM, then releases the core.
// Optional running checksum output enabled with `define BOOT_COPY_CHECKSUM_EN.
module rom_boot_copier
  import rom_boot_copier_pkg::*;
#(
  parameter logic [31:0] SrcBase   = 32'h0001_0000,
  parameter logic [31:0] DstBase   = 32'h2000_0000,
  parameter int unsigned NumWords  = 256,
  parameter bit          AutoStart = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  output tlul_pkg::tlul_h2d_t tl_h_o,
  input  tlul_pkg::tlul_d2h_t tl_h_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                core_rst_no
`ifdef BOOT_COPY_CHECKSUM_EN
  ,
  output logic [31:0]         checksum_o
`endif
);

  localparam logic [15:0] LastIdx = 16'(NumWords - 1);

  boot_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        done_q, err_q;
  logic        restart;
  logic        rd_accept;
  logic [31:0] word_off;

  assign word_off  = {14'd0, cnt_q, 2'b00};
  assign rd_accept = (state_q == ST_RD_RSP) && tl_h_i.d_valid && !tl_h_i.d_error;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= (state_d == ST_DONE);
      err_q   <= (state_d == ST_ERR);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    restart = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // IDLE is only reachable from reset, so AutoStart fires exactly once.
        if (start_i || AutoStart) begin
          state_d = ST_RD_REQ;
          cnt_d   = '0;
          restart = 1'b1;
        end
      end
      ST_RD_REQ: if (tl_h_i.a_ready) state_d = ST_RD_RSP;
      ST_RD_RSP: begin
        if (tl_h_i.d_valid) begin
          if (tl_h_i.d_error) begin
            state_d = ST_ERR;
          end else begin
            data_d  = tl_h_i.d_data;
            state_d = ST_WR_REQ;
          end
        end
      end
      ST_WR_REQ: if (tl_h_i.a_ready) state_d = ST_WR_RSP;
      ST_WR_RSP: begin
        if (tl_h_i.d_valid) begin
          if (tl_h_i.d_error) begin
            state_d = ST_ERR;
          end else begin
            cnt_d   = cnt_q + 16'd1;
            state_d = (cnt_q == LastIdx) ? ST_DONE : ST_RD_REQ;
          end
        end
      end
      ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d = ST_RD_REQ;
          cnt_d   = '0;
          restart = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields depend only on registered state, so they hold while a_ready is low.
  always_comb begin
    tl_h_o         = '0;
    tl_h_o.d_ready = 1'b1;
    tl_h_o.a_size  = 2'd2;
    tl_h_o.a_mask  = 4'hF;
    if (state_q == ST_RD_REQ) begin
      tl_h_o.a_valid   = 1'b1;
      tl_h_o.a_opcode  = OpGet;
      tl_h_o.a_address = SrcBase + word_off;
    end else if (state_q == ST_WR_REQ) begin
      tl_h_o.a_valid   = 1'b1;
      tl_h_o.a_opcode  = OpPutFullData;
      tl_h_o.a_address = DstBase + word_off;
      tl_h_o.a_data    = data_q;
    end
  end

  assign busy_o      = (state_q == ST_RD_REQ) || (state_q == ST_RD_RSP) ||
                       (state_q == ST_WR_REQ) || (state_q == ST_WR_RSP);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign core_rst_no = done_q;

`ifdef BOOT_COPY_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) csum_q <= '0;
    else         csum_q <= csum_d;
  end

  always_comb begin
    csum_d = csum_q;
    if (restart)        csum_d = '0;
    else if (rd_accept) csum_d = rotl1(csum_q) ^ tl_h_i.d_data;
  end

  assign checksum_o = csum_q;
`endif

  // Response metadata is not needed: one outstanding transaction identifies it.
  logic unused_tl;
  assign unused_tl = ^{tl_h_i.d_param, tl_h_i.d_size, tl_h_i.d_source, tl_h_i.d_sink,
                       tl_h_i.d_opcode == OpAccessAck, tl_h_i.d_opcode == OpAccessAckData,
                       rd_accept, restart};

endmodule

// File: tb/tb_rom_boot_copier.sv
// Self-checking bench for rom_boot_copier: zero-wait ROM/RAM device model with
// configurable stalls and error injection, table vectors plus directed corner cases.
module tb_rom_boot_copier;
  import rom_boot_copier_pkg::*;

  localparam int          N   = 4;
  localparam logic [31:0] SRC = 32'h0001_0000;
  localparam logic [31:0] DST = 32'h2000_0000;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n, start_i;
  logic busy_o, done_o, err_o, core_rst_no;
  tlul_pkg::tlul_h2d_t h2d;
  tlul_pkg::tlul_d2h_t d2h;
`ifdef BOOT_COPY_CHECKSUM_EN
  logic [31:0] checksum_o;
`endif

  always #5 clk = ~clk;

  rom_boot_copier #(.SrcBase(SRC), .DstBase(DST), .NumWords(N), .AutoStart(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i),
    .tl_h_o(h2d), .tl_h_i(d2h),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .core_rst_no(core_rst_no)
`ifdef BOOT_COPY_CHECKSUM_EN
    , .checksum_o(checksum_o)
`endif
  );

  // Configuration written by the stimulus process only.
  logic [31:0] rom_img [N];
  int stall_pct, stall_idx, stall_cfg, err_rd, err_wr, arm_idx;

  // Device model state written by the device process only.
  logic [31:0] ram [N];
  int hits [N];
  int wr_cnt, stall_seen, viol, stall_left;
  bit wr_armed, pend, prev_stalled;
  logic [31:0] pend_data;
  logic [2:0]  pend_op;
  bit pend_err;
  tlul_pkg::tlul_h2d_t prev_req;
  logic [31:0] rd_log [$];

  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    logic [31:0] off;
    bit rdy;
    if (!rst_n || start_i) begin
      wr_cnt = 0; stall_seen = 0; viol = 0; wr_armed = 0; stall_left = stall_cfg;
      rd_log.delete();
      for (int i = 0; i < N; i++) begin ram[i] = SENT; hits[i] = 0; end
      if (!rst_n) begin
        pend = 0; prev_stalled = 0; d2h = '0;
      end
    end
    if (rst_n) begin
      d2h.d_valid = 1'b0; d2h.d_error = 1'b0; d2h.d_data = '0;
      if (pend) begin
        if (h2d.a_valid) viol++;
        d2h.d_valid = 1'b1; d2h.d_data = pend_data; d2h.d_error = pend_err;
        d2h.d_opcode = pend_op; pend = 0;
      end
      if (prev_stalled && (h2d !== prev_req)) viol++;
      rdy = 1'b1;
      if (h2d.a_valid) begin
        if (h2d.a_opcode == OpPutFullData && h2d.a_address == DST + 32'(4 * stall_idx) &&
            stall_left > 0) begin
          rdy = 1'b0; stall_left--;
        end else if (int'($urandom_range(99)) < stall_pct) begin
          rdy = 1'b0;
        end
        if (!rdy) stall_seen++;
        else begin
          if (h2d.a_mask != 4'hF || h2d.a_size != 2'd2 || h2d.a_source != 8'd0 || !h2d.d_ready)
            viol++;
          pend = 1; pend_err = 0; pend_data = '0;
          if (h2d.a_opcode == OpGet) begin
            off = h2d.a_address - SRC;
            pend_op = OpAccessAckData;
            rd_log.push_back(h2d.a_address);
            if (off[1:0] != 2'd0 || off >= 32'(4 * N)) viol++;
            else begin
              pend_data = rom_img[off[31:2]];
              pend_err  = (int'(off[31:2]) == err_rd);
            end
          end else if (h2d.a_opcode == OpPutFullData) begin
            off = h2d.a_address - DST;
            pend_op = OpAccessAck;
            if (off[1:0] != 2'd0 || off >= 32'(4 * N)) viol++;
            else begin
              pend_err = (int'(off[31:2]) == err_wr);
              if (int'(off[31:2]) == arm_idx) wr_armed = 1;
              if (!pend_err) begin
                ram[off[31:2]] = h2d.a_data;
                hits[off[31:2]]++;
                wr_cnt++;
              end
            end
          end else viol++;
        end
      end
      prev_stalled = h2d.a_valid && !rdy;
      prev_req     = h2d;
      d2h.a_ready  = rdy;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_csum(input int n);
    logic [31:0] c = '0;
    for (int i = 0; i < n; i++) c = ((c << 1) | (c >> 31)) ^ rom_img[i];
    return c;
  endfunction

  task automatic verify_copy(input string tag, input bit exp_done, input bit exp_err,
                             input int exp_writes, input int exp_reads);
    check({tag, "_done"}, done_o, exp_done);
    check({tag, "_err"}, err_o, exp_err);
    check({tag, "_core_rst_n"}, core_rst_no, exp_done);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_writes"}, wr_cnt, exp_writes);
    check({tag, "_protocol"}, viol, 0);
    for (int i = 0; i < N; i++) begin
      if (i < exp_writes) check($sformatf("%s_ram%0d", tag, i), ram[i], rom_img[i]);
      else                check($sformatf("%s_nowrite%0d", tag, i), hits[i], 0);
    end
`ifdef BOOT_COPY_CHECKSUM_EN
    check({tag, "_checksum"}, checksum_o, ref_csum(exp_reads));
`endif
    $display("%s: done=%0b err=%0b writes=%0d reads_ok=%0d", tag, done_o, err_o, wr_cnt, exp_reads);
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done_o || err_o) && n < 2000) begin
      @(negedge clk); #1; n++;
    end
    if (!(done_o || err_o)) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done/err after %0d cycles, required completion", tag, n);
    end
  endtask

  task automatic do_start(input string tag);
    @(negedge clk); #1 start_i = 1'b1;
    @(negedge clk); #1 start_i = 1'b0;
    check({tag, "_start_busy"}, busy_o, 1'b1);
    check({tag, "_start_done_clr"}, done_o, 1'b0);
    check({tag, "_start_err_clr"}, err_o, 1'b0);
    check({tag, "_start_core_rst"}, core_rst_no, 1'b0);
  endtask

  typedef struct {
    int stall_pct; int err_rd; int err_wr; bit fixed12;
    bit exp_done; bit exp_err; int exp_writes; int exp_reads;
  } vec_t;

  initial begin
    vec_t vecs [7];
    int first, done_at;
    vecs[0] = '{0,  -1, -1, 0, 1, 0, 4, 4};
    vecs[1] = '{40, -1, -1, 0, 1, 0, 4, 4};
    vecs[2] = '{0,   2, -1, 1, 0, 1, 2, 2};
    vecs[3] = '{30, -1, -1, 0, 1, 0, 4, 4};
    vecs[4] = '{20, -1,  1, 0, 0, 1, 1, 2};
    vecs[5] = '{50,  0, -1, 0, 0, 1, 0, 0};
    vecs[6] = '{60, -1, -1, 1, 1, 0, 4, 4};

    rst_n = 1'b0; start_i = 1'b0;
    stall_pct = 0; stall_idx = -1; stall_cfg = 0; err_rd = -1; err_wr = -1; arm_idx = -1;
    for (int i = 0; i < N; i++) rom_img[i] = 32'h1111_1111 * (i + 1);
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_core_rst_n", core_rst_no, 1'b0);
    check("rst_a_valid", h2d.a_valid, 1'b0);
    check("rst_d_ready", h2d.d_ready, 1'b1);

    // Autostart copy with zero wait states: 4 cycles per word.
    @(negedge clk); rst_n = 1'b1;
    first = -1; done_at = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); #1;
      if (first < 0 && h2d.a_valid) first = n;
      if (done_o) begin done_at = n; break; end
    end
    check("auto_latency", done_at - first, 16);
    verify_copy("autostart", 1'b1, 1'b0, 4, 4);

    // Restart from DONE with a new image and a 5-cycle stall on the 2nd write.
    for (int i = 0; i < N; i++) rom_img[i] = 32'hA5A5_0000 + 32'(i * 3 + 7);
    stall_idx = 1; stall_cfg = 5;
    do_start("stall");
    wait_end("stall");
    verify_copy("stall", 1'b1, 1'b0, 4, 4);
    check("stall_cycles", stall_seen, 5);
    stall_idx = -1; stall_cfg = 0;

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < N; i++) rom_img[i] = $urandom;
      if (vecs[v].fixed12) begin rom_img[0] = 32'd1; rom_img[1] = 32'd2; end
      stall_pct = vecs[v].stall_pct; err_rd = vecs[v].err_rd; err_wr = vecs[v].err_wr;
      do_start($sformatf("vec%0d", v));
      wait_end($sformatf("vec%0d", v));
      repeat (3) @(negedge clk);
      #1;
      verify_copy($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err,
                  vecs[v].exp_writes, vecs[v].exp_reads);
    end
    stall_pct = 0; err_rd = -1; err_wr = -1;

    // Asynchronous reset during the write response of word 1, then autostart again.
    for (int i = 0; i < N; i++) rom_img[i] = $urandom;
    arm_idx = 1;
    do_start("rstmid");
    for (int n = 0; n < 100 && !wr_armed; n++) begin @(negedge clk); #1; end
    check("rstmid_armed", wr_armed, 1'b1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rstmid_busy", busy_o, 1'b0);
    check("rstmid_done", done_o, 1'b0);
    check("rstmid_err", err_o, 1'b0);
    check("rstmid_core_rst_n", core_rst_no, 1'b0);
    check("rstmid_a_valid", h2d.a_valid, 1'b0);
    check("rstmid_d_ready", h2d.d_ready, 1'b1);
    arm_idx = -1;
    @(negedge clk); @(negedge clk); #1 rst_n = 1'b1;
    wait_end("rstmid");
    verify_copy("rstmid", 1'b1, 1'b0, 4, 4);
    check("rstmid_first_rd", (rd_log.size() > 0) ? rd_log[0] : 32'hFFFF_FFFF, SRC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
